trace_capture_unit: RTL and testbench
=====================================

# trace_capture_unit

Synthesizable, parametrised trace recorder for the single-cycle RISC-V datapath. It sits beside `datapath` and samples `NextPC`, `Instruction` and `ALUResult` every clock while armed. It keeps the last `DEPTH` retired cycles in a circular buffer and stops on a PC trigger, a timeout or (optionally) ECALL/EBREAK. After stopping, it replays the captured entries oldest-first over a valid/ready stream, which lets benches and on-chip debug check execution without `$monitor`.

## Interface
- `XLEN`, 32, datapath word width for PC and ALU result
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `TIMEOUT`, 1024, maximum capture cycles before a forced stop; 1..65535
- `clock`  in  1  rising-edge clock, shared with `datapath`
- `Reset`  in  1  asynchronous, active-high reset
- `arm`  in  1  start request, sampled in IDLE only
- `trig_pc`  in  XLEN  stop when `NextPC` equals this value
- `NextPC`  in  XLEN  datapath next PC
- `Instruction`  in  32  datapath instruction
- `ALUResult`  in  XLEN  datapath ALU result
- `rd_valid`  out  1  readout entry available
- `rd_ready`  in  1  consumer accepts entry
- `rd_pc`, `rd_instr`, `rd_alu`  out  XLEN/32/XLEN  readout entry fields
- `state`  out  2  current FSM state
- `count`  out  $clog2(DEPTH)+1  valid entries held
- `wrapped`  out  1  oldest entries were overwritten
- `stop_cause`  out  2  0 none, 1 PC trigger, 2 timeout, 3 ECALL/EBREAK

## Operation
- FSM states: IDLE=0, CAPTURE=1, DRAIN=2.
- **IDLE**
  - `arm`=1 at an edge clears `count`, `wrapped`, `stop_cause` and the pointers, then moves to CAPTURE.
- **CAPTURE**
  - Every edge writes {NextPC, Instruction, ALUResult} at the write pointer and increments it modulo DEPTH.
  - When `count`==DEPTH, the write overwrites the oldest entry, the read pointer advances, `count` holds and `wrapped` sets.
  - Stop checks evaluate the same sampled values, in priority order: PC match (cause 1), ECALL/EBREAK (cause 3, macro only), cycle counter reaching TIMEOUT (cause 2).
  - The stopping cycle is itself recorded. On a stop, the FSM moves to DRAIN.
  - `arm` is ignored.
- **DRAIN**
  - `rd_valid` = (`count`≠0).
  - `rd_*` present the entry at the read pointer.
  - `rd_valid`&&`rd_ready` at an edge pops one entry (read pointer +1 mod DEPTH, `count`−1).
  - When `count` reaches 0, the FSM moves to IDLE. `stop_cause` and `wrapped` hold until the next arm.
  - `arm` is ignored.
- Arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally. The cycle counter is 16 bits and saturates at TIMEOUT.

## Timing
- Reset (asynchronous, immediate) forces:
  - `state`=IDLE; `count`, pointers, cycle counter = 0
  - `wrapped`=0, `stop_cause`=0, `rd_valid`=0
  - `rd_*` = 0 (gated while `rd_valid`=0)
  - Buffer contents are not cleared.
- Capture latency: `arm` at edge N means the first sample is taken at edge N+1.
- Stop: a trigger sampled at edge K gives `state`=DRAIN after K and `rd_valid`=1 after K.
- A PC trigger and a timeout in the same cycle report cause 1.
- Readout:
  - `rd_*` are combinational from registered storage.
  - One entry per cycle with `rd_ready` held high.
  - `rd_*` stay stable while `rd_valid`&&!`rd_ready`.
- Reset mid-capture or mid-drain discards the trace. No partial readout continues after `Reset` deasserts.

## Configuration
- `TRACE_ECALL_STOP_EN` defined:
  - An `Instruction` equal to 32'h00000073 (ECALL) or 32'h00100073 (EBREAK) during CAPTURE stops the capture with cause 3.
- `TRACE_ECALL_STOP_EN` undefined:
  - These instructions are recorded like any other.
  - Cause 3 is never produced.

## Structure
- Package `trace_pkg`:
  - state encoding constants: IDLE, CAPTURE, DRAIN
  - stop_cause constants
  - ECALL and EBREAK opcode constants
- One sub-module, `trace_ram`:
  - DEPTH × (2·XLEN+32) register array
  - one synchronous write port
  - one combinational read port
  - no reset on the array.

## Test plan
1. Arm, run 5 cycles with `trig_pc`=0x10 reached on the 5th → 5 entries drained in order, `stop_cause`=1, `wrapped`=0.
2. DEPTH=16, trigger on the 20th cycle → `count`=16, `wrapped`=1, first drained entry is cycle 5, last is cycle 20.
3. Trigger never matches, TIMEOUT=8 → 8 entries drained, `stop_cause`=2.
4. Readout with `rd_ready` toggling 1,0,0,1 → `rd_*` stable across stalls, no entry lost or duplicated, IDLE after the last pop.
5. `Reset` pulsed during DRAIN with 3 entries left → `rd_valid`=0 and `state`=IDLE immediately; re-arm captures fresh data.
6. With `TRACE_ECALL_STOP_EN` defined, `Instruction`=0x00000073 on the 3rd cycle → 3 entries drained, `stop_cause`=3. Without the macro, the capture continues.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture unit.
// ECALL/EBREAK opcodes are only used when TRACE_ECALL_STOP_EN is defined.
package trace_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDrain   = 2'd2
    } trace_state_e;

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CausePc      = 2'd1;
    localparam logic [1:0] CauseTimeout = 2'd2;
    localparam logic [1:0] CauseEnv     = 2'd3;

    localparam logic [31:0] InstrEcall  = 32'h0000_0073;
    localparam logic [31:0] InstrEbreak = 32'h0010_0073;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array with one synchronous write port and one
// combinational read port; contents are intentionally not reset.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_capture_unit.sv
// Circular trace recorder for the single-cycle datapath with oldest-first replay.
// Optional: define TRACE_ECALL_STOP_EN to stop capture on ECALL/EBREAK.
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     Reset,
    input  logic                     arm,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic [XLEN-1:0]          NextPC,
    input  logic [31:0]              Instruction,
    input  logic [XLEN-1:0]          ALUResult,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [XLEN-1:0]          rd_alu,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped,
    output logic [1:0]               stop_cause
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned WIDTH = 2 * XLEN + 32;

    localparam logic [CW-1:0] DepthCnt   = CW'(DEPTH);
    localparam logic [15:0]   TimeoutCnt = 16'(TIMEOUT);

    trace_state_e   state_q, state_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    cyc_q, cyc_d;
    logic           wrapped_q, wrapped_d;
    logic [1:0]     cause_q, cause_d;

    logic             we;
    logic [WIDTH-1:0] rdata;
    logic             pc_hit, env_hit, timeout_hit, pop;

    assign pc_hit      = (NextPC == trig_pc);
    assign timeout_hit = ((cyc_q + 16'd1) >= TimeoutCnt);

`ifdef TRACE_ECALL_STOP_EN
    assign env_hit = (Instruction == InstrEcall) || (Instruction == InstrEbreak);
`else
    assign env_hit = 1'b0;
`endif

    assign rd_valid = (state_q == StDrain) && (count_q != '0);
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        cyc_d     = cyc_q;
        wrapped_d = wrapped_q;
        cause_d   = cause_q;
        we        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    wptr_d    = '0;
                    rptr_d    = '0;
                    count_d   = '0;
                    cyc_d     = '0;
                    wrapped_d = 1'b0;
                    cause_d   = CauseNone;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                we     = 1'b1;
                wptr_d = wptr_q + 1'b1;
                // Full buffer: the write lands on the oldest entry, so skip past it.
                if (count_q == DepthCnt) begin
                    rptr_d    = rptr_q + 1'b1;
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
                cyc_d = timeout_hit ? TimeoutCnt : cyc_q + 16'd1;
                if (pc_hit) begin
                    cause_d = CausePc;
                    state_d = StDrain;
                end else if (env_hit) begin
                    cause_d = CauseEnv;
                    state_d = StDrain;
                end else if (timeout_hit) begin
                    cause_d = CauseTimeout;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop) begin
                    rptr_d  = rptr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state_d = StIdle;
                    end
                end else if (count_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            cyc_q     <= '0;
            wrapped_q <= 1'b0;
            cause_q   <= CauseNone;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            cyc_q     <= cyc_d;
            wrapped_q <= wrapped_d;
            cause_q   <= cause_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i ({NextPC, Instruction, ALUResult}),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

    assign rd_pc      = rd_valid ? rdata[WIDTH-1 -: XLEN] : '0;
    assign rd_instr   = rd_valid ? rdata[XLEN+31 -: 32]   : '0;
    assign rd_alu     = rd_valid ? rdata[XLEN-1:0]        : '0;
    assign state      = state_q;
    assign count      = count_q;
    assign wrapped    = wrapped_q;
    assign stop_cause = cause_q;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit; honours TRACE_ECALL_STOP_EN when defined.
module tb_trace_capture_unit;

    logic        clock = 1'b0;
    logic        Reset;
    logic        arm, arm_b, rd_ready;
    logic [31:0] trig_pc, NextPC, Instruction, ALUResult;

    logic        a_valid, b_valid;
    logic [31:0] a_pc, a_instr, a_alu, b_pc, b_instr, b_alu;
    logic [1:0]  a_state, b_state, a_cause, b_cause;
    logic [4:0]  a_count, b_count;
    logic        a_wrapped, b_wrapped;

    int checks = 0;
    int errors = 0;

    logic [31:0] base_pc  = 32'h0;
    logic [31:0] base_alu = 32'h100;
    int          ecall_at = 0;

    always #5 clock = ~clock;

    trace_capture_unit #(.XLEN(32), .DEPTH(16), .TIMEOUT(1024)) dut (
        .clock(clock), .Reset(Reset), .arm(arm), .trig_pc(trig_pc), .NextPC(NextPC),
        .Instruction(Instruction), .ALUResult(ALUResult), .rd_valid(a_valid),
        .rd_ready(rd_ready), .rd_pc(a_pc), .rd_instr(a_instr), .rd_alu(a_alu),
        .state(a_state), .count(a_count), .wrapped(a_wrapped), .stop_cause(a_cause)
    );

    trace_capture_unit #(.XLEN(32), .DEPTH(16), .TIMEOUT(8)) dut_to (
        .clock(clock), .Reset(Reset), .arm(arm_b), .trig_pc(trig_pc), .NextPC(NextPC),
        .Instruction(Instruction), .ALUResult(ALUResult), .rd_valid(b_valid),
        .rd_ready(rd_ready), .rd_pc(b_pc), .rd_instr(b_instr), .rd_alu(b_alu),
        .state(b_state), .count(b_count), .wrapped(b_wrapped), .stop_cause(b_cause)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc_of(input int i);
        return base_pc + 32'(4 * (i - 1));
    endfunction

    function automatic logic [31:0] instr_of(input int i);
        return (i == ecall_at) ? 32'h0000_0073 : (32'h13 | (32'(i) << 20));
    endfunction

    function automatic logic [31:0] alu_of(input int i);
        return base_alu + 32'(i * 3);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic arm_a();
        arm = 1'b1;
        step();
        arm = 1'b0;
        check_eq("arm_state", a_state, 2'd1);
    endtask

    task automatic capture_n(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            NextPC      = pc_of(i);
            Instruction = instr_of(i);
            ALUResult   = alu_of(i);
            step();
        end
    endtask

    task automatic drain_a(input int first, input int n);
        rd_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("drain_valid_%0d", k), a_valid, 1'b1);
            check_eq($sformatf("drain_pc_%0d", k), a_pc, pc_of(first + k));
            check_eq($sformatf("drain_instr_%0d", k), a_instr, instr_of(first + k));
            check_eq($sformatf("drain_alu_%0d", k), a_alu, alu_of(first + k));
            step();
        end
        check_eq("drain_end_state", a_state, 2'd0);
        check_eq("drain_end_valid", a_valid, 1'b0);
        check_eq("drain_end_pc_gated", a_pc, 32'h0);
        rd_ready = 1'b0;
    endtask

    initial begin
        int idx;
        logic [3:0] pat;
        Reset = 1'b1; arm = 1'b0; arm_b = 1'b0; rd_ready = 1'b0;
        trig_pc = 32'hFFFF_FFF0; NextPC = '0; Instruction = '0; ALUResult = '0;
        step();
        step();
        Reset = 1'b0;
        check_eq("rst_state", a_state, 2'd0);
        check_eq("rst_count", a_count, 5'd0);
        check_eq("rst_wrapped", a_wrapped, 1'b0);
        check_eq("rst_cause", a_cause, 2'd0);
        check_eq("rst_valid", a_valid, 1'b0);
        check_eq("rst_pc", a_pc, 32'h0);
        check_eq("rst_b_state", b_state, 2'd0);

        // 1: PC trigger on the 5th sample
        trig_pc = 32'h10;
        arm_a();
        capture_n(1, 4);
        check_eq("t1_still_capture", a_state, 2'd1);
        capture_n(5, 1);
        check_eq("t1_state", a_state, 2'd2);
        check_eq("t1_count", a_count, 5'd5);
        check_eq("t1_cause", a_cause, 2'd1);
        check_eq("t1_wrapped", a_wrapped, 1'b0);
        drain_a(1, 5);
        check_eq("t1_cause_hold", a_cause, 2'd1);

        // 2: wrap-around, trigger on the 20th sample
        trig_pc = pc_of(20);
        arm_a();
        check_eq("t2_rearm_cause", a_cause, 2'd0);
        capture_n(1, 20);
        check_eq("t2_state", a_state, 2'd2);
        check_eq("t2_count", a_count, 5'd16);
        check_eq("t2_wrapped", a_wrapped, 1'b1);
        drain_a(5, 16);
        check_eq("t2_wrapped_hold", a_wrapped, 1'b1);

        // 3: timeout on the TIMEOUT=8 instance
        trig_pc = 32'hFFFF_FFF0;
        arm_b = 1'b1;
        step();
        arm_b = 1'b0;
        capture_n(1, 7);
        check_eq("t3_still_capture", b_state, 2'd1);
        capture_n(8, 1);
        check_eq("t3_state", b_state, 2'd2);
        check_eq("t3_count", b_count, 5'd8);
        check_eq("t3_cause", b_cause, 2'd2);
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("t3_valid_%0d", k), b_valid, 1'b1);
            check_eq($sformatf("t3_pc_%0d", k), b_pc, pc_of(k + 1));
            step();
        end
        rd_ready = 1'b0;
        check_eq("t3_end_state", b_state, 2'd0);
        check_eq("t3_a_idle", a_state, 2'd0);

        // 4: stalled readout with rd_ready pattern 1,0,0,1
        trig_pc = pc_of(4);
        arm_a();
        capture_n(1, 4);
        check_eq("t4_state", a_state, 2'd2);
        pat = 4'b1001;
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            rd_ready = pat[c % 4];
            check_eq($sformatf("t4_valid_c%0d", c), a_valid, 1'b1);
            check_eq($sformatf("t4_pc_c%0d", c), a_pc, pc_of(idx + 1));
            check_eq($sformatf("t4_alu_c%0d", c), a_alu, alu_of(idx + 1));
            step();
            if (rd_ready) idx++;
        end
        rd_ready = 1'b0;
        check_eq("t4_popped", 64'(idx), 64'd4);
        check_eq("t4_idle", a_state, 2'd0);

        // 5: reset during drain with 3 entries left, then fresh capture
        trig_pc = 32'h10;
        arm_a();
        capture_n(1, 5);
        rd_ready = 1'b1;
        step();
        step();
        rd_ready = 1'b0;
        check_eq("t5_count_before", a_count, 5'd3);
        #2 Reset = 1'b1;
        #1;
        check_eq("t5_rst_valid", a_valid, 1'b0);
        check_eq("t5_rst_state", a_state, 2'd0);
        check_eq("t5_rst_count", a_count, 5'd0);
        check_eq("t5_rst_cause", a_cause, 2'd0);
        step();
        Reset = 1'b0;
        base_pc  = 32'h2000;
        base_alu = 32'h5000;
        trig_pc  = pc_of(3);
        arm_a();
        capture_n(1, 3);
        check_eq("t5_state", a_state, 2'd2);
        check_eq("t5_count", a_count, 5'd3);
        drain_a(1, 3);
        base_pc  = 32'h0;
        base_alu = 32'h100;

        // 6: ECALL on the 3rd sample
        ecall_at = 3;
        trig_pc  = 32'hFFFF_FFF0;
        arm_a();
        capture_n(1, 3);
`ifdef TRACE_ECALL_STOP_EN
        check_eq("t6_state", a_state, 2'd2);
        check_eq("t6_cause", a_cause, 2'd3);
        check_eq("t6_count", a_count, 5'd3);
        drain_a(1, 3);
`else
        check_eq("t6_state", a_state, 2'd1);
        check_eq("t6_cause", a_cause, 2'd0);
        trig_pc = pc_of(6);
        capture_n(4, 3);
        check_eq("t6_stop_state", a_state, 2'd2);
        check_eq("t6_stop_cause", a_cause, 2'd1);
        check_eq("t6_count", a_count, 5'd6);
        drain_a(1, 6);
`endif
        ecall_at = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
